// File: rtl/pipe_reg_elastic_pkg.sv
// pipe_reg_elastic_pkg: shared pipeline-register types, limits and lane masking helper.
package pipe_reg_elastic_pkg;
    localparam int MAX_LANES = 4;
    localparam int MAX_WIDTH = 128;
    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;
    function automatic logic [MAX_WIDTH-1:0] lane_mask_apply(input logic [MAX_WIDTH-1:0] d, input logic m);
        return m ? d : '0;
    endfunction
endpackage

// File: rtl/pipe_reg_elastic_entry.sv
// pipe_entry: one register slot holding a lane mask plus payload, with load and clear.
module pipe_entry #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (rst || clr) ? '0 : ld ? d : q;
endmodule

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: elastic multi-lane stage register with flush, lane masking and optional skid slot.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES-1:0]       in_lane_mask_i,
    input  logic [LANES*WIDTH-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES-1:0]       out_lane_mask_o,
    output logic [LANES*WIDTH-1:0] out_data_o,
    output logic [1:0]             occupancy_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);
    localparam int EW = LANES*WIDTH + LANES;
    pipe_state_t state, state_n;
    logic acc, dq, main_ld, main_clr, skid_ld;
    logic [LANES*WIDTH-1:0] in_masked;
    logic [EW-1:0] in_entry, main_d, main_q, skid_q;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign in_masked[k*WIDTH +: WIDTH] =
            WIDTH'(lane_mask_apply(MAX_WIDTH'(in_data_i[k*WIDTH +: WIDTH]), in_lane_mask_i[k]));
    end
    assign in_entry = {in_lane_mask_i, in_masked};
    assign acc = in_valid_i & in_ready_o;
    assign dq  = out_valid_o & out_ready_i;
    always_ff @(posedge clk)
        state <= rst ? PS_EMPTY : state_n;
    // With SKID=0 acc in PS_ONE implies dq, so PS_FULL is never reached.
    always_comb
        state_n = flush_i ? PS_EMPTY :
                  state == PS_EMPTY ? (acc ? PS_ONE : PS_EMPTY) :
                  state == PS_ONE ? (acc ? (dq ? PS_ONE : PS_FULL) : (dq ? PS_EMPTY : PS_ONE)) :
                  (dq ? PS_ONE : PS_FULL);
    always_comb begin
        out_valid_o = state != PS_EMPTY;
        in_ready_o  = (SKID != 0) ? state != PS_FULL : (~out_valid_o | out_ready_i);
        occupancy_o = state == PS_FULL ? 2'd2 : state == PS_ONE ? 2'd1 : 2'd0;
    end
    // Main is reloaded from skid when draining FULL, otherwise from input; cleared when it drains empty.
    assign main_ld  = (acc & (state == PS_EMPTY | dq)) | (state == PS_FULL & dq);
    assign main_clr = flush_i | (dq & ~main_ld);
    assign main_d   = state == PS_FULL ? skid_q : in_entry;
    assign skid_ld  = acc & ~dq & (state == PS_ONE);
    pipe_entry #(.W(EW)) u_main (
        .clk(clk), .rst(rst), .clr(main_clr), .ld(main_ld), .d(main_d), .q(main_q)
    );
    if (SKID != 0) begin : g_skid
        pipe_entry #(.W(EW)) u_skid (
            .clk(clk), .rst(rst), .clr(flush_i), .ld(skid_ld), .d(in_entry), .q(skid_q)
        );
    end else begin : g_noskid
        assign skid_q = '0;
    end
    assign out_lane_mask_o = main_q[EW-1 -: LANES];
    assign out_data_o      = main_q[LANES*WIDTH-1:0];
    always_ff @(posedge clk)
        stall_cnt_o <= rst ? '0 :
                       (out_valid_o && !out_ready_i && stall_cnt_o != '1) ? stall_cnt_o + 1'b1 :
                       stall_cnt_o;
endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the fixed IF/ID stage register, usable between any two pipeline stages.
- Carries LANES payload slots of WIDTH bits each, with a per-lane valid mask, a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer.
- The skid buffer breaks the combinational ready path.
- Invalid or flushed slots present all-zero payload, so that downstream decode sees 0x00000000 as a bubble.

Parameters:
- WIDTH, 32, payload bits per lane (PC, instruction and prediction bundle packed by the instantiating stage).
- LANES, 1, number of parallel payload lanes (1..4).
- SKID, 1, 1 = 2-entry skid (registered in_ready_o); 0 = single register with combinational ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  discard all held and incoming payload this cycle
- in_valid_i  in  1  upstream offers a bundle
- in_ready_o  out  1  stage can accept a bundle
- in_lane_mask_i  in  LANES  per-lane valid bits of the offered bundle
- in_data_i  in  LANES*WIDTH  payload; lane k occupies bits [k*WIDTH +: WIDTH]
- out_valid_o  out  1  bundle presented downstream
- out_ready_i  in  1  downstream accepts
- out_lane_mask_o  out  LANES  per-lane valid of the presented bundle
- out_data_o  out  LANES*WIDTH  presented payload; 0 in lanes whose mask bit is 0
- occupancy_o  out  2  entries held (0..2; never exceeds 1 when SKID=0)
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Reset (rst=1, synchronous): clears all entries. Outputs become out_valid_o=0, out_lane_mask_o=0, out_data_o=0, occupancy_o=0, stall_cnt_o=0. in_ready_o=1 from the first cycle after reset.
- Handshakes:
  - acc = in_valid_i & in_ready_o.
  - dq = out_valid_o & out_ready_i.
  - Data captured on acc appears at the output the next cycle (latency 1) when the stage was empty or dq occurs.
- SKID=1 state machine, registers main (output) and skid:
  - EMPTY: acc -> ONE (main <= in).
  - ONE: acc & dq -> ONE (main <= in). acc & ~dq -> FULL (skid <= in). ~acc & dq -> EMPTY. Otherwise hold.
  - FULL: dq -> ONE (main <= skid); otherwise hold. in_ready_o=0, so no acc is possible.
  - in_ready_o = (state != FULL); it is a registered signal with no combinational path from out_ready_i.
  - Ordering is strictly FIFO; skid contents are never overtaken by new input.
- SKID=0:
  - Single entry; in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - acc loads the entry; dq without acc empties it.
- Flush:
  - flush_i=1 forces state EMPTY next cycle.
  - All masks and data are zeroed, the incoming bundle is dropped even if acc, and an in-flight dq is still counted as delivered this cycle.
  - rst has priority over flush_i.
- Lane mask:
  - A bundle with in_valid_i=1 and in_lane_mask_i=0 is accepted and forwarded as an all-bubble bundle (out_valid_o=1, mask 0).
  - Each lane's data is ANDed with its mask bit on capture.
- Stall counter:
  - Increments when out_valid_o & ~out_ready_i, saturating at 2^CNT_W-1.
  - Cleared only by rst; unaffected by flush_i.
- occupancy_o equals the number of valid entries: 0 for EMPTY, 1 for ONE, 2 for FULL.

Decomposition:
- Shared pipeline package (beside rv32i_types) holds:
  - lane-count limit constant MAX_LANES = 4;
  - typedef pipe_state_t enum {PS_EMPTY, PS_ONE, PS_FULL};
  - function lane_mask_apply for zeroing masked lanes.
- One natural sub-module: pipe_entry, a single WIDTH*LANES+LANES register slot with load/clear. It is instantiated twice for SKID=1 and once for SKID=0.

Test Plan:
- Reset: assert rst 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o=0, occupancy_o=0, then in_ready_o=1.
- Streaming (SKID=1, LANES=2, out_ready_i=1): drive data {0x00000013, 0x00400093}, mask 2'b11, every cycle -> the same bundle appears at the output 1 cycle later, throughput 1/cycle, occupancy_o=1.
- Backpressure: drop out_ready_i for 3 cycles mid-stream -> occupancy_o reaches 2, in_ready_o=0 on the next cycle, no bundle lost or reordered, stall_cnt_o=3.
- Flush while FULL with acc attempted -> next cycle out_valid_o=0, out_data_o=0, occupancy_o=0, stall_cnt_o unchanged, dropped bundle never appears.
- Lane masking: mask 2'b01 with lane 1 data 0xDEADBEEF -> out_data_o lane 1 = 0, lane 0 passes through.
- SKID=0: out_ready_i toggling 1,0,1 with continuous input -> in_ready_o follows ~out_valid_o | out_ready_i in the same cycle; the output sequence matches the input order.
